// File: rtl/vproc_pkg.sv
// Shared vector-core types and helpers: register group encoding, result-store
// sequencer states and the register address formation shared with operand fetch.
package vproc_pkg;

    typedef enum logic [1:0] {
        EMUL_1 = 2'd0,
        EMUL_2 = 2'd1,
        EMUL_4 = 2'd2,
        EMUL_8 = 2'd3
    } cfg_emul;

    typedef enum logic {
        STORE_IDLE = 1'b0,
        STORE_BUSY = 1'b1
    } store_seq_state;

    // OR rather than add: a misaligned vd aliases inside its group, exactly as fetch does.
    function automatic logic [4:0] store_addr(input logic [4:0] vd, input logic [2:0] cnt);
        return vd | {2'b00, cnt};
    endfunction

    function automatic logic [2:0] emul_last_cnt(input cfg_emul emul);
        return 3'((4'd1 << emul) - 4'd1);
    endfunction

endpackage

// File: rtl/vproc_result_store_if.sv
// Bundle of descriptor, result-beat, register-file write and completion signals
// between a functional unit / register file and the result-store sequencer.
interface vproc_result_store_if #(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned ID_W   = 3
) ();
    import vproc_pkg::*;

    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [4:0]            instr_vd_i;
    cfg_emul               instr_emul_i;
    logic                  instr_narrow_i;
    logic [ID_W-1:0]       instr_id_i;

    logic                  res_valid_i;
    logic                  res_ready_o;
    logic [VREG_W-1:0]     res_data_i;
    logic [VREG_W/8-1:0]   res_be_i;

    logic                  vreg_wr_en_o;
    logic [4:0]            vreg_wr_addr_o;
    logic [VREG_W-1:0]     vreg_wr_data_o;
    logic [VREG_W/8-1:0]   vreg_wr_be_o;
    logic [31:0]           clear_wr_hazard_o;
    logic                  done_valid_o;
    logic [ID_W-1:0]       done_id_o;

    modport slave (
        input  instr_valid_i, instr_vd_i, instr_emul_i, instr_narrow_i, instr_id_i,
        input  res_valid_i, res_data_i, res_be_i,
        output instr_ready_o, res_ready_o,
        output vreg_wr_en_o, vreg_wr_addr_o, vreg_wr_data_o, vreg_wr_be_o,
        output clear_wr_hazard_o, done_valid_o, done_id_o
    );

    modport master (
        output instr_valid_i, instr_vd_i, instr_emul_i, instr_narrow_i, instr_id_i,
        output res_valid_i, res_data_i, res_be_i,
        input  instr_ready_o, res_ready_o,
        input  vreg_wr_en_o, vreg_wr_addr_o, vreg_wr_data_o, vreg_wr_be_o,
        input  clear_wr_hazard_o, done_valid_o, done_id_o
    );

endinterface

// File: rtl/vproc_narrow_pack.sv
// Half-width pack buffer for narrowing results: holds the first half-beat of a
// register until its partner arrives; hi_o says the next beat completes the pair.
module vproc_narrow_pack #(
    parameter int unsigned HALF_W = 64
) (
    input  logic                clk_i,
    input  logic                async_rst_ni,
    input  logic                clear_i,
    input  logic                beat_i,
    input  logic [HALF_W-1:0]   data_i,
    input  logic [HALF_W/8-1:0] be_i,
    output logic                hi_o,
    output logic [HALF_W-1:0]   data_o,
    output logic [HALF_W/8-1:0] be_o
);

    logic                hi_q;
    logic [HALF_W-1:0]   data_q;
    logic [HALF_W/8-1:0] be_q;

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            hi_q   <= 1'b0;
            data_q <= '0;
            be_q   <= '0;
        end else if (clear_i) begin
            hi_q   <= 1'b0;
            data_q <= '0;
            be_q   <= '0;
        end else if (beat_i) begin
            if (!hi_q) begin
                data_q <= data_i;
                be_q   <= be_i;
            end
            hi_q <= ~hi_q;
        end
    end

    assign hi_o   = hi_q;
    assign data_o = data_q;
    assign be_o   = be_q;

endmodule

// File: rtl/vproc_result_store.sv
// Result-store sequencer: takes one destination descriptor per instruction and
// turns the unit's result beats into register-file writes for the whole group.
module vproc_result_store
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned ID_W   = 3
) (
    input  logic                 clk_i,
    input  logic                 async_rst_ni,
    vproc_result_store_if.slave  bus
);

    localparam int unsigned BE_W   = VREG_W / 8;
    localparam int unsigned HALF_W = VREG_W / 2;
    localparam int unsigned HBE_W  = VREG_W / 16;

    store_seq_state    state_q, state_d;
    logic [4:0]        vd_q, vd_d;
    logic              narrow_q, narrow_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [VREG_W-1:0] wr_data_q, wr_data_d;
    logic [BE_W-1:0]   wr_be_q, wr_be_d;
    logic [31:0]       hazard_q, hazard_d;
    logic              done_valid_q, done_valid_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;

    logic              instr_accept;
    logic              beat;
    logic              pack_hi;
    logic [HALF_W-1:0] pack_data;
    logic [HBE_W-1:0]  pack_be;

    assign instr_accept = (state_q == STORE_IDLE) && bus.instr_valid_i;
    assign beat         = (state_q == STORE_BUSY) && bus.res_valid_i;

    vproc_narrow_pack #(
        .HALF_W (HALF_W)
    ) u_pack (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .clear_i      (instr_accept),
        .beat_i       (beat && narrow_q),
        .data_i       (bus.res_data_i[HALF_W-1:0]),
        .be_i         (bus.res_be_i[HBE_W-1:0]),
        .hi_o         (pack_hi),
        .data_o       (pack_data),
        .be_o         (pack_be)
    );

    always_comb begin
        state_d      = state_q;
        vd_d         = vd_q;
        narrow_d     = narrow_q;
        id_d         = id_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        wr_be_d      = '0;
        done_valid_d = 1'b0;
        done_id_d    = '0;

        unique case (state_q)
            STORE_IDLE: begin
                if (bus.instr_valid_i) begin
                    state_d  = STORE_BUSY;
                    vd_d     = bus.instr_vd_i;
                    narrow_d = bus.instr_narrow_i;
                    id_d     = bus.instr_id_i;
                    last_d   = emul_last_cnt(bus.instr_emul_i);
                    cnt_d    = 3'd0;
                end
            end
            STORE_BUSY: begin
                // A narrow beat only writes once its pair partner is already buffered.
                if (beat && (!narrow_q || pack_hi)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = store_addr(vd_q, cnt_q);
                    wr_data_d = narrow_q ? {bus.res_data_i[HALF_W-1:0], pack_data} : bus.res_data_i;
                    wr_be_d   = narrow_q ? {bus.res_be_i[HBE_W-1:0], pack_be} : bus.res_be_i;
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == last_q) begin
                        done_valid_d = 1'b1;
                        done_id_d    = id_q;
                        state_d      = STORE_IDLE;
                    end
                end
            end
            default: state_d = STORE_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_hazard
        assign hazard_d[gi] = wr_en_d && (wr_addr_d == 5'(gi));
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q      <= STORE_IDLE;
            vd_q         <= '0;
            narrow_q     <= 1'b0;
            id_q         <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_be_q      <= '0;
            hazard_q     <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            vd_q         <= vd_d;
            narrow_q     <= narrow_d;
            id_q         <= id_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_be_q      <= wr_be_d;
            hazard_q     <= hazard_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
        end
    end

    assign bus.instr_ready_o     = (state_q == STORE_IDLE);
    assign bus.res_ready_o       = (state_q == STORE_BUSY);
    assign bus.vreg_wr_en_o      = wr_en_q;
    assign bus.vreg_wr_addr_o    = wr_addr_q;
    assign bus.vreg_wr_data_o    = wr_data_q;
    assign bus.vreg_wr_be_o      = wr_be_q;
    assign bus.clear_wr_hazard_o = hazard_q;
    assign bus.done_valid_o      = done_valid_q;
    assign bus.done_id_o         = done_id_q;

endmodule

// File: tb/tb_vproc_result_store.sv
// Randomized bench for the result-store sequencer: a directed opening sequence
// then random descriptors and beat gaps, checked cycle by cycle against a model.
module tb_vproc_result_store;
    import vproc_pkg::*;

    localparam int VREG_W = 128;
    localparam int ID_W   = 3;
    localparam int NCYC   = 4000;
    localparam int NDIR   = 7;

    logic clk;
    logic async_rst_ni;

    vproc_result_store_if #(.VREG_W(VREG_W), .ID_W(ID_W)) bus ();

    vproc_result_store #(.VREG_W(VREG_W), .ID_W(ID_W)) dut (
        .clk_i        (clk),
        .async_rst_ni (async_rst_ni),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Directed opening descriptors: vd, emul, narrow, id
    logic [4:0] dir_vd     [NDIR] = '{5'd4, 5'd8, 5'd3, 5'd6, 5'd0, 5'd10, 5'd11};
    logic [1:0] dir_emul   [NDIR] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    logic       dir_narrow [NDIR] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] dir_id     [NDIR] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd6};

    // Expected outputs for the current cycle
    logic              e_ir, e_rr, e_wen, e_done;
    logic [4:0]        e_addr;
    logic [VREG_W-1:0] e_data;
    logic [15:0]       e_be;
    logic [31:0]       e_haz;
    logic [ID_W-1:0]   e_id;

    // Reference model state
    bit          m_busy;
    logic [4:0]  m_vd;
    bit          m_narrow;
    logic [2:0]  m_id;
    int          m_k, m_total, m_idx;
    logic [63:0] buf_data;
    logic [7:0]  buf_be;

    // Pending descriptor
    bit          p_valid;
    int          p_idx;
    logic [4:0]  p_vd;
    logic [1:0]  p_emul;
    bit          p_narrow;
    logic [2:0]  p_id;
    int          desc_cnt;
    bit          reset_armed;
    bit          directed;

    task automatic exp_idle_outputs();
        e_wen = 1'b0; e_addr = '0; e_data = '0; e_be = '0; e_haz = '0;
        e_done = 1'b0; e_id = '0;
        e_ir = !m_busy; e_rr = m_busy;
    endtask

    task automatic check_outputs();
        chk("instr_ready", 128'(bus.instr_ready_o), 128'(e_ir));
        chk("res_ready",   128'(bus.res_ready_o),   128'(e_rr));
        chk("wr_en",       128'(bus.vreg_wr_en_o),  128'(e_wen));
        chk("wr_addr",     128'(bus.vreg_wr_addr_o), 128'(e_addr));
        chk("wr_data",     bus.vreg_wr_data_o,      e_data);
        chk("wr_be",       128'(bus.vreg_wr_be_o),  128'(e_be));
        chk("hazard",      128'(bus.clear_wr_hazard_o), 128'(e_haz));
        chk("done_valid",  128'(bus.done_valid_o),  128'(e_done));
        chk("done_id",     128'(bus.done_id_o),     128'(e_id));
        if (bus.done_valid_o) begin
            n_txn++;
            $display("txn %0d: id=%0d last_addr=%0d be=%h", n_txn, bus.done_id_o,
                     bus.vreg_wr_addr_o, bus.vreg_wr_be_o);
        end
    endtask

    initial begin
        int reg_idx;
        async_rst_ni       = 1'b0;
        bus.instr_valid_i  = 1'b0;
        bus.instr_vd_i     = '0;
        bus.instr_emul_i   = EMUL_1;
        bus.instr_narrow_i = 1'b0;
        bus.instr_id_i     = '0;
        bus.res_valid_i    = 1'b0;
        bus.res_data_i     = '0;
        bus.res_be_i       = '0;
        m_busy = 0; m_k = 0; m_total = 0; m_idx = -1;
        p_valid = 0; desc_cnt = 0; reset_armed = 0;
        buf_data = '0; buf_be = '0;
        exp_idle_outputs();

        repeat (2) @(negedge clk);
        check_outputs();
        async_rst_ni = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            check_outputs();

            // Reset pulse while only the first narrow half-beat is buffered
            if (reset_armed && m_busy && m_narrow && m_k == 1) begin
                reset_armed       = 0;
                bus.instr_valid_i = 1'b0;
                bus.res_valid_i   = 1'b0;
                async_rst_ni      = 1'b0;
                m_busy            = 0;
                #1;
                exp_idle_outputs();
                check_outputs();
                @(negedge clk);
                check_outputs();
                async_rst_ni = 1'b1;
                continue;
            end

            if (!p_valid) begin
                p_valid = 1;
                p_idx   = desc_cnt;
                if (desc_cnt < NDIR) begin
                    p_vd = dir_vd[desc_cnt]; p_emul = dir_emul[desc_cnt];
                    p_narrow = dir_narrow[desc_cnt]; p_id = dir_id[desc_cnt];
                end else begin
                    p_vd = 5'($urandom_range(0, 31)); p_emul = 2'($urandom_range(0, 3));
                    p_narrow = 1'($urandom_range(0, 1)); p_id = 3'($urandom_range(0, 7));
                end
                desc_cnt++;
            end
            directed = (m_busy ? m_idx : p_idx) < NDIR;

            bus.instr_valid_i  = p_valid && (directed || $urandom_range(0, 3) != 0);
            bus.instr_vd_i     = p_vd;
            bus.instr_emul_i   = cfg_emul'(p_emul);
            bus.instr_narrow_i = p_narrow;
            bus.instr_id_i     = p_id;
            bus.res_valid_i    = directed ? (cyc % 4 == 0 || cyc % 4 == 3)
                                          : ($urandom_range(0, 3) != 0);
            bus.res_data_i     = {$urandom, $urandom, $urandom, $urandom};
            bus.res_be_i       = 16'($urandom);
            if (m_busy && m_idx == 1) begin
                bus.res_data_i[63:0] = (m_k == 0) ? {8{8'hAA}} : {8{8'hBB}};
                bus.res_be_i         = (m_k == 0) ? 16'h00FF : 16'h0F0F;
            end

            // Predict the outputs the next edge produces
            exp_idle_outputs();
            if (!m_busy) begin
                if (bus.instr_valid_i) begin
                    m_busy   = 1;
                    m_vd     = p_vd;
                    m_narrow = p_narrow;
                    m_id     = p_id;
                    m_idx    = p_idx;
                    m_k      = 0;
                    m_total  = (1 << p_emul) * (p_narrow ? 2 : 1);
                    p_valid  = 0;
                    if (p_idx == 4) reset_armed = 1;
                end
            end else if (bus.res_valid_i) begin
                if (m_narrow && (m_k % 2 == 0)) begin
                    buf_data = bus.res_data_i[63:0];
                    buf_be   = bus.res_be_i[7:0];
                end else begin
                    reg_idx = m_narrow ? m_k / 2 : m_k;
                    e_wen   = 1'b1;
                    e_addr  = m_vd | 5'(reg_idx);
                    e_data  = m_narrow ? {bus.res_data_i[63:0], buf_data} : bus.res_data_i;
                    e_be    = m_narrow ? {bus.res_be_i[7:0], buf_be} : bus.res_be_i;
                    e_haz   = 32'd1 << e_addr;
                    if (m_k == m_total - 1) begin
                        e_done = 1'b1;
                        e_id   = m_id;
                        m_busy = 0;
                    end
                end
                m_k++;
            end
            e_ir = !m_busy;
            e_rr = m_busy;

            @(negedge clk);
        end

        chk("txn_count_nonzero", 128'(n_txn > 20), 128'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
